// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state encoding and default widths for the CPU run sequencer.
package cpu_run_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_FINISH = 3'd4
  } run_state_t;

endpackage

// File: rtl/run_addr_fifo.sv
// run_addr_fifo: small synchronous FIFO of program start addresses.
// Head is visible combinationally so the sequencer can launch it in the pop cycle.
// full/empty are registered; a push while full is dropped, a pop while empty is ignored.
module run_addr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          push_ok;
  logic          pop_ok;

  // Full is judged on occupancy before any same-cycle pop.
  assign push_ok    = push && !full_reg;
  assign pop_ok     = pop && !empty_reg;
  assign count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

  // Storage array carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally on AW bits; flags track the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: queues CPU program start addresses, launches each with a
// one-cycle start pulse, waits for done and reports address plus cycle count.
// Optional watchdog: define RUN_SEQ_TIMEOUT_EN to abort runs at TIMEOUT_CYCLES.
module cpu_run_sequencer
  import cpu_run_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              full_o,
  input  logic              go_i,
  output logic              cpu_start_o,
  output logic [ADDR_W-1:0] cpu_start_addr_o,
  input  logic              cpu_done_i,
  output logic              result_valid_o,
  output logic [ADDR_W-1:0] result_addr_o,
  output logic [CNT_W-1:0]  result_cycles_o,
  output logic              result_timeout_o,
  output logic              busy_o,
  output logic              all_done_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cpu_run_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  run_state_t        state_reg;
  run_state_t        state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] head;
  logic              empty;
  logic              launching;
  logic              watchdog_hit;

  assign launching = (state_reg == ST_LAUNCH);

  run_addr_fifo #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock_i),
    .rst       (reset_i),
    .push      (push_i),
    .push_data (push_addr_i),
    .pop       (launching),
    .head      (head),
    .full      (full_o),
    .empty     (empty)
  );

`ifdef RUN_SEQ_TIMEOUT_EN
  logic timeout_reg;

  assign watchdog_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

  // Remember whether the run left RUN through the watchdog rather than done.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      timeout_reg <= 1'b0;
    end else if (launching) begin
      timeout_reg <= 1'b0;
    end else if (state_reg == ST_RUN && state_next == ST_REPORT) begin
      timeout_reg <= !cpu_done_i;
    end
  end

  assign result_timeout_o = (state_reg == ST_REPORT) && timeout_reg;
`else
  assign watchdog_hit     = 1'b0;
  assign result_timeout_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state: done has priority over the watchdog in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (go_i) state_next = empty ? ST_FINISH : ST_LAUNCH;
      ST_LAUNCH: state_next = ST_RUN;
      ST_RUN: begin
        if (cpu_done_i)        state_next = ST_REPORT;
        else if (watchdog_hit) state_next = ST_REPORT;
      end
      ST_REPORT: state_next = empty ? ST_FINISH : ST_LAUNCH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Cycle counter: cleared on launch, counts only cycles that stay in RUN, saturates.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_reg <= '0;
    end else if (launching) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_RUN && state_next == ST_RUN && cnt_reg != '1) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Capture the launched address; it stays on the CPU port until the next launch.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)        addr_reg <= '0;
    else if (launching) addr_reg <= head;
  end

  assign cpu_start_o      = launching;
  assign cpu_start_addr_o = launching ? head : addr_reg;
  assign result_valid_o   = (state_reg == ST_REPORT);
  assign result_addr_o    = result_valid_o ? addr_reg : '0;
  assign result_cycles_o  = result_valid_o ? cnt_reg : '0;
  assign busy_o           = (state_reg != ST_IDLE);
  assign all_done_o       = (state_reg == ST_FINISH);

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb_cpu_run_sequencer: directed bench with a latency-programmable CPU model.
// Build with RUN_SEQ_TIMEOUT_EN defined to exercise the watchdog path.
module tb_cpu_run_sequencer;

  logic        clock_i     = 1'b0;
  logic        reset_i     = 1'b1;
  logic        push_i      = 1'b0;
  logic [7:0]  push_addr_i = 8'd0;
  logic        go_i        = 1'b0;
  logic        cpu_done_i  = 1'b0;
  logic        full_o;
  logic        cpu_start_o;
  logic [7:0]  cpu_start_addr_o;
  logic        result_valid_o;
  logic [7:0]  result_addr_o;
  logic [14:0] result_cycles_o;
  logic        result_timeout_o;
  logic        busy_o;
  logic        all_done_o;

  cpu_run_sequencer #(
    .ADDR_W         (8),
    .CNT_W          (15),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .push_i           (push_i),
    .push_addr_i      (push_addr_i),
    .full_o           (full_o),
    .go_i             (go_i),
    .cpu_start_o      (cpu_start_o),
    .cpu_start_addr_o (cpu_start_addr_o),
    .cpu_done_i       (cpu_done_i),
    .result_valid_o   (result_valid_o),
    .result_addr_o    (result_addr_o),
    .result_cycles_o  (result_cycles_o),
    .result_timeout_o (result_timeout_o),
    .busy_o           (busy_o),
    .all_done_o       (all_done_o)
  );

  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // CPU model: done drops when start is sampled and rises in the lat-th cycle after start.
  int   lat  = 10;
  int   mcnt = 0;
  logic mrun = 1'b0;
  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cpu_done_i <= 1'b0;
      mcnt       <= 0;
      mrun       <= 1'b0;
    end else if (cpu_start_o) begin
      cpu_done_i <= 1'b0;
      mcnt       <= 1;
      mrun       <= 1'b1;
    end else if (mrun) begin
      if (lat != 0 && mcnt == lat - 1) begin
        cpu_done_i <= 1'b1;
        mrun       <= 1'b0;
      end
      mcnt <= mcnt + 1;
    end
  end

  // Cycle counter and event monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int n_start = 0, n_res = 0, n_done = 0, done_cyc = 0;
  int st_cyc[16], st_addr[16], rs_cyc[16], rs_addr[16], rs_cnt[16], rs_to[16];
  always @(negedge clock_i) begin
    if (cpu_start_o) begin
      if (n_start < 16) begin
        st_cyc[n_start]  = cyc;
        st_addr[n_start] = int'(cpu_start_addr_o);
      end
      n_start++;
      $display("cycle %0d start addr=%0d", cyc, cpu_start_addr_o);
    end
    if (result_valid_o) begin
      if (n_res < 16) begin
        rs_cyc[n_res]  = cyc;
        rs_addr[n_res] = int'(result_addr_o);
        rs_cnt[n_res]  = int'(result_cycles_o);
        rs_to[n_res]   = int'(result_timeout_o);
      end
      n_res++;
      $display("cycle %0d result addr=%0d cycles=%0d timeout=%0d", cyc, result_addr_o, result_cycles_o, result_timeout_o);
    end
    if (all_done_o) begin
      done_cyc = cyc;
      n_done++;
      $display("cycle %0d all_done", cyc);
    end
  end

  task automatic clear_log();
    @(posedge clock_i);
    n_start = 0;
    n_res   = 0;
    n_done  = 0;
  endtask

  task automatic push(input int a);
    @(negedge clock_i);
    push_i      = 1'b1;
    push_addr_i = a[7:0];
    @(negedge clock_i);
    push_i = 1'b0;
  endtask

  task automatic go(output int gc);
    @(negedge clock_i);
    go_i = 1'b1;
    gc   = cyc;
    @(negedge clock_i);
    go_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k;
    k = 0;
    while (n_done == 0 && k < maxc) begin
      @(negedge clock_i);
      k++;
    end
    check(tag, 32'(n_done != 0), 32'd1);
  endtask

  int g;
  int burst[5] = '{11, 22, 33, 44, 55};

  initial begin
    // Reset state.
    repeat (3) @(negedge clock_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_start", 32'(cpu_start_o), 0);
    check("rst_addr", 32'(cpu_start_addr_o), 0);
    check("rst_valid", 32'(result_valid_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_alldone", 32'(all_done_o), 0);
    reset_i = 1'b0;

    // Single run, done in the 10th RUN cycle -> cycles 9.
    clear_log();
    lat = 10;
    push(93);
    go(g);
    wait_done("t1_wait", 100);
    check("t1_nstart", n_start, 1);
    check("t1_staddr", st_addr[0], 93);
    check("t1_stcyc", st_cyc[0], g + 1);
    check("t1_nres", n_res, 1);
    check("t1_raddr", rs_addr[0], 93);
    check("t1_rcnt", rs_cnt[0], 9);
    check("t1_rto", rs_to[0], 0);
    check("t1_rlat", rs_cyc[0] - st_cyc[0], 11);
    check("t1_dlat", done_cyc - rs_cyc[0], 1);
    check("t1_holdaddr", 32'(cpu_start_addr_o), 93);

    // Two entries, back to back.
    clear_log();
    push(93);
    push(138);
    go(g);
    wait_done("t2_wait", 200);
    check("t2_nres", n_res, 2);
    check("t2_addr0", rs_addr[0], 93);
    check("t2_addr1", rs_addr[1], 138);
    check("t2_cnt1", rs_cnt[1], 9);
    check("t2_gap", st_cyc[1] - rs_cyc[0], 1);
    check("t2_ndone", n_done, 1);

    // Five back-to-back pushes into a 4-deep queue.
    clear_log();
    @(negedge clock_i);
    for (int i = 0; i < 5; i++) begin
      push_i      = 1'b1;
      push_addr_i = burst[i][7:0];
      @(negedge clock_i);
      if (i == 2) check("t3_notfull3", 32'(full_o), 0);
      if (i == 3) check("t3_full4", 32'(full_o), 1);
    end
    push_i = 1'b0;
    go(g);
    wait_done("t3_wait", 300);
    check("t3_nres", n_res, 4);
    check("t3_nstart", n_start, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_addr%0d", i), rs_addr[i], burst[i]);
    check("t3_fullafter", 32'(full_o), 0);

    // Empty go; then go pulsed during RUN is ignored.
    clear_log();
    go(g);
    wait_done("t4_wait", 10);
    check("t4_dcyc", done_cyc, g + 1);
    check("t4_nstart", n_start, 0);
    clear_log();
    lat = 30;
    push(7);
    go(g);
    repeat (5) @(negedge clock_i);
    go_i = 1'b1;
    @(negedge clock_i);
    go_i = 1'b0;
    wait_done("t4b_wait", 200);
    repeat (10) @(negedge clock_i);
    check("t4b_nstart", n_start, 1);
    check("t4b_nres", n_res, 1);
    check("t4b_rcnt", rs_cnt[0], 29);
    check("t4b_ndone", n_done, 1);

    // Reset during LAUNCH drops the start pulse asynchronously.
    push(3);
    go(g);
    check("t5_launch", 32'(cpu_start_o), 1);
    #1 reset_i = 1'b1;
    #1 check("t5_start_async", 32'(cpu_start_o), 0);
    @(negedge clock_i);
    reset_i = 1'b0;

    // Reset mid-RUN flushes the queue and produces no results.
    push(1);
    push(2);
    go(g);
    repeat (5) @(negedge clock_i);
    check("t6_busy_pre", 32'(busy_o), 1);
    #2 reset_i = 1'b1;
    #1;
    check("t6_busy", 32'(busy_o), 0);
    check("t6_addr", 32'(cpu_start_addr_o), 0);
    check("t6_valid", 32'(result_valid_o), 0);
    @(negedge clock_i);
    #2 reset_i = 1'b0;
    clear_log();
    repeat (60) @(negedge clock_i);
    check("t6_nres", n_res, 0);
    check("t6_ndone", n_done, 0);
    go(g);
    wait_done("t6_wait", 10);
    check("t6_dcyc", done_cyc, g + 1);
    check("t6_nstart", n_start, 0);

    // CPU never finishes.
    clear_log();
    lat = 0;
    push(9);
    go(g);
`ifdef RUN_SEQ_TIMEOUT_EN
    wait_done("t7_wait", 200);
    check("t7_nres", n_res, 1);
    check("t7_to", rs_to[0], 1);
    check("t7_cnt", rs_cnt[0], 50);
    check("t7_rlat", rs_cyc[0] - st_cyc[0], 52);
`else
    repeat (1000) @(negedge clock_i);
    check("t7_busy", 32'(busy_o), 1);
    check("t7_nres", n_res, 0);
`endif
    #2 reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
